// File: rtl/riscv_definitions.sv
// Shared definitions for the boot-time program loader.
package riscv_definitions;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_HOLD, LD_RUN} loader_state_t;

   // Byte address of a full-word slot counted from a base byte address.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] index);
      return base + (index << 2);
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: streams instruction words into imem as full-word stores, then
// hands the memory port to the core and releases its reset.
module imem_loader #(
   parameter int          DATA_WIDTH = riscv_definitions::DATA_WIDTH,
   parameter int          MAX_WORDS  = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          RST_HOLD   = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_start,
   input  logic [$clog2(MAX_WORDS+1)-1:0] i_num_words,
   input  logic                           i_word_valid,
   input  logic [DATA_WIDTH-1:0]          i_word_data,
   output logic                           o_word_ready,
   output logic                           o_mem_we,
   output logic [3:0]                     o_mem_ctrl,
   output logic [31:0]                    o_mem_addr,
   output logic [DATA_WIDTH-1:0]          o_mem_di,
   output logic                           o_init_active,
   output logic                           o_cpu_rst_n,
   output logic                           o_busy,
   output logic                           o_done,
   output logic                           o_error
);
   import riscv_definitions::*;

   localparam int CW = $clog2(MAX_WORDS + 1);
   localparam int HW = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);

   loader_state_t state;
   logic [CW-1:0] idx;
   logic [CW-1:0] count;
   logic [HW-1:0] hold_cnt;
   logic          too_many;
   logic          empty_load;
   logic          xfer;
   logic          hold_done;

   assign too_many   = 32'(i_num_words) > 32'(MAX_WORDS);
   assign empty_load = (i_num_words == '0);

   assign o_word_ready = (state == LD_LOAD) && (idx < count);
   assign xfer         = o_word_ready && i_word_valid;

   // The write cycle itself is the first of the RST_HOLD cycles, so HOLD
   // lasts RST_HOLD-1 cycles (at least one).
   assign hold_done = (32'(hold_cnt) + 32'd2) >= 32'(RST_HOLD);

   assign o_busy = (state == LD_LOAD) || (state == LD_HOLD);
   assign o_done = (state == LD_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= LD_IDLE;
         idx           <= '0;
         count         <= '0;
         hold_cnt      <= '0;
         o_mem_we      <= 1'b0;
         o_mem_ctrl    <= 4'b0000;
         o_mem_addr    <= BASE_ADDR;
         o_mem_di      <= '0;
         o_init_active <= 1'b1;
         o_cpu_rst_n   <= 1'b0;
         o_error       <= 1'b0;
      end else begin
         o_mem_we   <= 1'b0;
         o_mem_ctrl <= 4'b0000;
         case (state)
            LD_IDLE, LD_RUN: begin
               if (i_start) begin
                  o_cpu_rst_n <= 1'b0;
                  if (too_many) begin
                     o_error       <= 1'b1;
                     o_init_active <= 1'b1;
                     state         <= LD_IDLE;
                  end else if (empty_load) begin
                     o_error       <= 1'b0;
                     o_init_active <= 1'b0;
                     hold_cnt      <= '0;
                     state         <= LD_HOLD;
                  end else begin
                     o_error       <= 1'b0;
                     o_init_active <= 1'b1;
                     count         <= i_num_words;
                     idx           <= '0;
                     state         <= LD_LOAD;
                  end
               end
            end
            LD_LOAD: begin
               if (xfer) begin
                  o_mem_we   <= 1'b1;
                  o_mem_ctrl <= 4'b1111;
                  o_mem_addr <= word_addr(BASE_ADDR, 32'(idx));
                  o_mem_di   <= i_word_data;
                  idx        <= idx + CW'(1);
               end else if (idx == count) begin
                  // Final write is on the bus this cycle; release the mux after it.
                  o_init_active <= 1'b0;
                  hold_cnt      <= '0;
                  state         <= LD_HOLD;
               end
            end
            LD_HOLD: begin
               if (hold_done) begin
                  o_cpu_rst_n <= 1'b1;
                  state       <= LD_RUN;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: state <= LD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle model compared every cycle plus literal checks.
module tb_imem_loader;
   localparam int          DW = 32;
   localparam int          MW = 32;
   localparam int          RH = 2;
   localparam logic [31:0] BA = 32'h0000_0000;
   localparam int          NW = $clog2(MW + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [NW-1:0] num = '0;
   logic          valid = 1'b0;
   logic [DW-1:0] data = '0;
   logic          ready, we, init_active, cpu_rst_n, busy, done, error;
   logic [3:0]    ctrl;
   logic [31:0]   addr;
   logic [DW-1:0] di;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   imem_loader #(.DATA_WIDTH(DW), .MAX_WORDS(MW), .BASE_ADDR(BA), .RST_HOLD(RH)) dut (
      .clk(clk), .rst(rst), .i_start(start), .i_num_words(num),
      .i_word_valid(valid), .i_word_data(data), .o_word_ready(ready),
      .o_mem_we(we), .o_mem_ctrl(ctrl), .o_mem_addr(addr), .o_mem_di(di),
      .o_init_active(init_active), .o_cpu_rst_n(cpu_rst_n), .o_busy(busy),
      .o_done(done), .o_error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model: phase 0 idle, 1 loading, 2 holding, 3 running.
   int          m_phase, m_count, m_taken, m_hold;
   bit          m_we, m_init, m_rstn, m_err;
   logic [31:0] m_addr, m_di;

   always @(posedge clk) begin : model
      bit xfer;
      int pre;
      if (rst) begin
         m_phase = 0; m_count = 0; m_taken = 0; m_hold = 0;
         m_we = 0; m_addr = BA; m_di = 0; m_init = 1; m_rstn = 0; m_err = 0;
      end else begin
         pre  = m_taken;
         xfer = (m_phase == 1) && (m_taken < m_count) && valid;
         m_we = xfer;
         if (xfer) begin
            m_addr  = BA + 32'(4 * m_taken);
            m_di    = data;
            m_taken = m_taken + 1;
         end
         case (m_phase)
            0, 3: if (start) begin
               m_rstn = 0;
               if (int'(num) > MW) begin m_err = 1; m_init = 1; m_phase = 0; end
               else if (num == 0) begin m_err = 0; m_init = 0; m_hold = RH - 1; m_phase = 2; end
               else begin m_err = 0; m_init = 1; m_count = int'(num); m_taken = 0; m_phase = 1; end
            end
            1: if (pre == m_count) begin m_phase = 2; m_init = 0; m_hold = RH - 1; end
            2: begin
               m_hold = m_hold - 1;
               if (m_hold <= 0) begin m_phase = 3; m_rstn = 1; end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin : compare
      logic [74:0] exp_v, act_v;
      if (chk_en) begin
         exp_v = {(m_phase == 1) && (m_taken < m_count), m_we, m_we ? 4'hF : 4'h0, m_addr, m_di,
                  m_init, m_rstn, (m_phase == 1) || (m_phase == 2), m_phase == 3, m_err};
         act_v = {ready, we, ctrl, addr, di, init_active, cpu_rst_n, busy, done, error};
         vectors++;
         if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle_model cyc=%0d actual=%h required=%h", cyc, act_v, exp_v);
         end
      end
   end

   // Write log and reset-release timestamp.
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          wc[$];
   int          rise_cyc = -1;
   int          start_cyc = 0;
   bit          prev_rstn = 1'b0;

   always @(negedge clk) begin
      if (chk_en && we === 1'b1) begin wa.push_back(addr); wd.push_back(di); wc.push_back(cyc); end
      if (cpu_rst_n === 1'b1 && !prev_rstn) rise_cyc = cyc;
      prev_rstn = (cpu_rst_n === 1'b1);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h", name, got, want);
      end
   endtask

   task automatic clear_log();
      wa.delete(); wd.delete(); wc.delete(); rise_cyc = -1;
   endtask

   task automatic do_start(input int n);
      @(negedge clk); start = 1'b1; num = NW'(n); start_cyc = cyc;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send(input logic [31:0] w, input int gap);
      int g;
      repeat (gap) begin @(negedge clk); valid = 1'b0; end
      @(negedge clk); valid = 1'b1; data = w;
      g = 0;
      while (ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) chk("send_timeout", 32'(g), 32'd0);
   endtask

   task automatic load_words(input int n, input logic [31:0] base_word, input int gap);
      for (int i = 0; i < n; i++) send(base_word + 32'(i), (i == 0) ? 0 : gap);
      @(negedge clk); valid = 1'b0;
   endtask

   task automatic wait_rstn();
      int g;
      g = 0;
      while (cpu_rst_n !== 1'b1 && g < 100) begin @(negedge clk); g++; end
      #1;
      if (g >= 100) chk("rstn_timeout", 32'(g), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk); chk_en = 1'b1; rst = 1'b0;
      #1;
      chk("reset_init_active", 32'(init_active), 32'd1);
      chk("reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("reset_addr", addr, BA);
      chk("reset_ready", 32'(ready), 32'd0);

      // 1: four words back-to-back
      clear_log();
      do_start(4);
      load_words(4, 32'hA000_0000, 0);
      wait_rstn();
      chk("t1_nwrites", 32'(wa.size()), 32'd4);
      for (int i = 0; i < 4 && i < wa.size(); i++) begin
         chk("t1_addr", wa[i], 32'(4 * i));
         chk("t1_data", wd[i], 32'hA000_0000 + 32'(i));
         if (i > 0) chk("t1_consecutive", 32'(wc[i] - wc[i-1]), 32'd1);
      end
      if (wc.size() == 4) chk("t1_hold_delay", 32'(rise_cyc - wc[3]), 32'(RH));
      chk("t1_done", 32'(done), 32'd1);

      // 2: same load with valid toggling, re-armed from RUN
      clear_log();
      do_start(4);
      load_words(4, 32'hB000_0000, 1);
      wait_rstn();
      chk("t2_nwrites", 32'(wa.size()), 32'd4);
      for (int i = 0; i < 4 && i < wa.size(); i++) begin
         chk("t2_addr", wa[i], 32'(4 * i));
         chk("t2_data", wd[i], 32'hB000_0000 + 32'(i));
         if (i > 0) chk("t2_spacing", 32'(wc[i] - wc[i-1]), 32'd2);
      end

      // 3: oversize load rejected from IDLE
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      clear_log();
      do_start(33);
      #1;
      chk("t3_error", 32'(error), 32'd1);
      chk("t3_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      #1;
      chk("t3_no_writes", 32'(wa.size()), 32'd0);
      chk("t3_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("t3_error_sticky", 32'(error), 32'd1);

      // 4: zero-word load
      clear_log();
      do_start(0);
      #1;
      chk("t4_init_active", 32'(init_active), 32'd0);
      chk("t4_error_clear", 32'(error), 32'd0);
      wait_rstn();
      chk("t4_no_writes", 32'(wa.size()), 32'd0);
      chk("t4_hold_delay", 32'(rise_cyc - start_cyc), 32'(RH));
      chk("t4_done", 32'(done), 32'd1);

      // 5: reset mid-load, then a fresh 3-word load
      clear_log();
      do_start(8);
      send(32'hD000_0000, 0);
      send(32'hD000_0001, 0);
      @(negedge clk); valid = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      #1;
      chk("t5_we_after_rst", 32'(we), 32'd0);
      chk("t5_rstn_after_rst", 32'(cpu_rst_n), 32'd0);
      chk("t5_busy_after_rst", 32'(busy), 32'd0);
      clear_log();
      do_start(3);
      load_words(3, 32'hE000_0000, 0);
      wait_rstn();
      chk("t5_nwrites", 32'(wa.size()), 32'd3);
      for (int i = 0; i < 3 && i < wa.size(); i++) chk("t5_addr", wa[i], BA + 32'(4 * i));

      // 6: re-arm from RUN, full-capacity load
      clear_log();
      do_start(32);
      #1;
      chk("t6_rstn_drop", 32'(cpu_rst_n), 32'd0);
      chk("t6_init_active", 32'(init_active), 32'd1);
      load_words(32, 32'hC000_0000, 0);
      wait_rstn();
      chk("t6_nwrites", 32'(wa.size()), 32'd32);
      if (wa.size() == 32) begin
         chk("t6_last_addr", wa[31], 32'd124);
         chk("t6_last_data", wd[31], 32'hC000_001F);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
